updown_mod_counter: RTL and testbench

//   Parametrised up/down counter with programmable modulus, wrap or saturate

---
 rtl/updown_mod_counter_if.sv | 22 ++
 rtl/updown_mod_counter.sv | 94 +++++++++
 tb/tb_updown_mod_counter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_mod_counter_if
// Description : Control/status bundle for updown_mod_counter. The master
//               drives enable, direction and load. The slave returns the
//               count and the terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_mod_counter_if #(
   parameter int WIDTH = 4
) ();
   logic             en;
   logic             m;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;

   modport master (output en, m, load, load_val, input  count, tc);
   modport slave  (input  en, m, load, load_val, output count, tc);
endinterface
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_mod_counter
// Description : Parametrised up/down counter. It has a programmable modulus
//               (MAX_VAL+1), wrap or saturate behaviour at the boundaries, a
//               synchronous clamped load, an enable-qualified prescaler and a
//               registered one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 15,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  wire logic           clk,
   input  wire logic           rst,      // asynchronous, active-low
   updown_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] C_ZERO = '0;

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_step;

   generate
      if (PRESCALE > 1) begin : g_prescale
         localparam int               C_PW    = $clog2(PRESCALE);
         localparam logic [C_PW-1:0]  C_PLAST = C_PW'(PRESCALE - 1);
         logic [C_PW-1:0] r_pcnt;

         // Prescaler phase: cleared by load, advances only on enabled cycles
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_pcnt <= '0;
            end else if (bus.load) begin
               r_pcnt <= '0;
            end else if (bus.en) begin
               r_pcnt <= (r_pcnt == C_PLAST) ? '0 : r_pcnt + 1'b1;
            end
         end

         assign w_step = bus.en & (r_pcnt == C_PLAST);
      end else begin : g_no_prescale
         assign w_step = bus.en;
      end
   endgenerate

   // Next count / tc: load beats step, step beats hold; tc only on boundary steps
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      if (bus.load) begin
         w_count_nxt = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
      end else if (w_step) begin
         if (bus.m) begin
            // >= rather than == keeps the count bounded even from a stray value
            if (r_count >= C_MAX) begin
               w_tc_nxt    = 1'b1;
               w_count_nxt = (SATURATE != 0) ? C_MAX : C_ZERO;
            end else begin
               w_count_nxt = r_count + 1'b1;
            end
         end else begin
            if (r_count == C_ZERO) begin
               w_tc_nxt    = 1'b1;
               w_count_nxt = (SATURATE != 0) ? C_ZERO : C_MAX;
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end
      end
   end

   // Count and terminal-count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_mod_counter
// Description : Self-checking bench. Three counters (WIDTH=4, MAX_VAL=9):
//               wrap, saturate, and wrap with PRESCALE=3. They share one
//               stimulus stream. A behavioural model pushes the expected
//               count/tc into a scoreboard queue on every driven cycle. The
//               queue is popped after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(4)) if_w ();
   updown_mod_counter_if #(.WIDTH(4)) if_s ();
   updown_mod_counter_if #(.WIDTH(4)) if_p ();

   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1))
      dut_w (.clk(clk), .rst(rst), .bus(if_w));
   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1))
      dut_s (.clk(clk), .rst(rst), .bus(if_s));
   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3))
      dut_p (.clk(clk), .rst(rst), .bus(if_p));

   typedef struct {
      int         dut;
      logic [3:0] c;
      logic       t;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state, one slot per counter: wrap, saturate, prescale
   int mc[3];
   int mt[3];
   int mp[3];
   int SAT[3] = '{0, 1, 0};
   int PRE[3] = '{1, 1, 3};

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mc[k] = 0; mt[k] = 0; mp[k] = 0;
      end
   endtask

   task automatic model_edge(input logic en, input logic m, input logic load,
                             input logic [3:0] lv);
      logic stp;
      for (int k = 0; k < 3; k++) begin
         if (!rst) begin
            mc[k] = 0; mt[k] = 0; mp[k] = 0;
         end else if (load) begin
            mc[k] = (lv > 4'd9) ? 9 : int'(lv);
            mp[k] = 0;
            mt[k] = 0;
         end else if (!en) begin
            mt[k] = 0;
         end else begin
            if (mp[k] == PRE[k] - 1) begin
               mp[k] = 0; stp = 1'b1;
            end else begin
               mp[k] = mp[k] + 1; stp = 1'b0;
            end
            mt[k] = 0;
            if (stp) begin
               if (m) begin
                  if (mc[k] == 9) begin
                     mt[k] = 1;
                     if (SAT[k] == 0) mc[k] = 0;
                  end else mc[k] = mc[k] + 1;
               end else begin
                  if (mc[k] == 0) begin
                     mt[k] = 1;
                     if (SAT[k] == 0) mc[k] = 9;
                  end else mc[k] = mc[k] - 1;
               end
            end
         end
      end
   endtask

   // Drive one cycle, push expectations, clock, then pop and compare
   task automatic cycle(input logic en, input logic m, input logic load,
                        input logic [3:0] lv, input string tag);
      exp_t       e;
      logic [3:0] ac;
      logic       at;
      if_w.en = en; if_w.m = m; if_w.load = load; if_w.load_val = lv;
      if_s.en = en; if_s.m = m; if_s.load = load; if_s.load_val = lv;
      if_p.en = en; if_p.m = m; if_p.load = load; if_p.load_val = lv;
      model_edge(en, m, load, lv);
      for (int k = 0; k < 3; k++)
         q.push_back('{k, 4'(mc[k]), mt[k][0], tag});
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.dut)
            0:       begin ac = if_w.count; at = if_w.tc; end
            1:       begin ac = if_s.count; at = if_s.tc; end
            default: begin ac = if_p.count; at = if_p.tc; end
         endcase
         n_checks++;
         if (ac !== e.c) begin
            n_fail++;
            $display("FAIL %s dut%0d count: got %0d expected %0d", e.tag, e.dut, ac, e.c);
         end
         n_checks++;
         if (at !== e.t) begin
            n_fail++;
            $display("FAIL %s dut%0d tc: got %0b expected %0b", e.tag, e.dut, at, e.t);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 4'd0, "pre_reset_idle");
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({if_w.count, if_s.count, if_p.count} !== 12'd0 ||
          {if_w.tc, if_s.tc, if_p.tc} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_async: counts %0d/%0d/%0d tc %0b%0b%0b expected all 0",
                  if_w.count, if_s.count, if_p.count, if_w.tc, if_s.tc, if_p.tc);
      end
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "reset_held1");
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "reset_held2");
      rst = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "reset_first_step");
      n_checks++;
      if (if_w.count !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_first_step_const: got %0d expected 1", if_w.count);
      end
   endtask

   task automatic test_wrap_up();
      cycle(1'b0, 1'b1, 1'b1, 4'd0, "wrap_load0");
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, "wrap_up");
      n_checks++;
      if (if_w.count !== 4'd2 || if_w.tc !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_up_end: got %0d/%0b expected 2/0", if_w.count, if_w.tc);
      end
   endtask

   task automatic test_down();
      cycle(1'b0, 1'b0, 1'b1, 4'd0, "down_load0");
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "down_wrap");
      n_checks++;
      if (if_w.count !== 4'd9 || if_w.tc !== 1'b1) begin
         n_fail++;
         $display("FAIL down_wrap_const: got %0d/%0b expected 9/1", if_w.count, if_w.tc);
      end
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "down_step");
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "down_step");
      cycle(1'b0, 1'b1, 1'b0, 4'd0, "down_flip_hold");
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "down_flip_up");
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "down_flip_back");
      n_checks++;
      if (if_w.count !== 4'd7) begin
         n_fail++;
         $display("FAIL down_flip_const: got %0d expected 7", if_w.count);
      end
   endtask

   task automatic test_saturate();
      cycle(1'b0, 1'b1, 1'b1, 4'd8, "sat_load8");
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, "sat_up");
      n_checks++;
      if (if_s.count !== 4'd9 || if_s.tc !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_hold_const: got %0d/%0b expected 9/1", if_s.count, if_s.tc);
      end
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "sat_down");
      n_checks++;
      if (if_s.count !== 4'd8 || if_s.tc !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_down_const: got %0d/%0b expected 8/0", if_s.count, if_s.tc);
      end
      cycle(1'b0, 1'b0, 1'b1, 4'd0, "sat_load0");
      cycle(1'b1, 1'b0, 1'b0, 4'd0, "sat_low_hold");
   endtask

   task automatic test_load();
      cycle(1'b1, 1'b1, 1'b1, 4'd12, "load_clamp");
      n_checks++;
      if (if_w.count !== 4'd9 || if_w.tc !== 1'b0) begin
         n_fail++;
         $display("FAIL load_clamp_const: got %0d/%0b expected 9/0", if_w.count, if_w.tc);
      end
      cycle(1'b1, 1'b0, 1'b1, 4'd3, "load_beats_step");
      cycle(1'b1, 1'b1, 1'b1, 4'd15, "load_clamp15");
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "load_then_wrap");
   endtask

   task automatic test_prescale();
      cycle(1'b0, 1'b1, 1'b1, 4'd0, "pre_load0");
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, "pre_run");
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 4'd0, "pre_en_low");
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "pre_phase_held");
      n_checks++;
      if (if_p.count !== 4'd2) begin
         n_fail++;
         $display("FAIL pre_phase_const: got %0d expected 2", if_p.count);
      end
      cycle(1'b1, 1'b1, 1'b0, 4'd0, "pre_run2");
      // asynchronous reset pulse between edges
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (if_p.count !== 4'd0 || if_w.count !== 4'd0) begin
         n_fail++;
         $display("FAIL pre_async_rst: got %0d/%0d expected 0/0", if_p.count, if_w.count);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, "pre_after_rst");
      n_checks++;
      if (if_p.count !== 4'd1) begin
         n_fail++;
         $display("FAIL pre_after_rst_const: got %0d expected 1", if_p.count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), "random");
   endtask

   initial begin
      if_w.en = 0; if_w.m = 0; if_w.load = 0; if_w.load_val = 0;
      if_s.en = 0; if_s.m = 0; if_s.load = 0; if_s.load_val = 0;
      if_p.en = 0; if_p.m = 0; if_p.load = 0; if_p.load_val = 0;
      rst = 1'b1;
      model_reset();
      #2;
      test_reset();
      test_wrap_up();
      test_down();
      test_saturate();
      test_load();
      test_prescale();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
